decode_stage_pipe: RTL and testbench

- Pipelined, parametrised successor to the single-cycle RV32I decoder.
- Sits between fetch and execute, with a registered ID/EX output and valid/ready handshakes on both sides.
- Adds load-use hazard stalling, flush on redirect, early JAL redirect and illegal-instruction flagging.
- Combinational field and control decode lives in a sub-module; this block owns the pipeline register and hazard control.

---
 rtl/riscv_decode_pkg.sv | 46 ++++
 rtl/decode_stage_pipe_if.sv | 39 +++
 rtl/decode_core.sv | 62 ++++++
 rtl/decode_stage_pipe.sv | 67 ++++++
 tb/tb_decode_stage_pipe.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/riscv_decode_pkg.sv
// riscv_decode_pkg: RV32I opcodes, ALU/operand encodings and the decoded-control record
package riscv_decode_pkg;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b001000;
    localparam logic [5:0] ALU_SLT = 6'b000010;
    localparam logic [5:0] ALU_XOR = 6'b000100;
    localparam logic [5:0] ALU_AND = 6'b000111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'b00,
        OPA_PC   = 2'b01,
        OPA_PC4  = 2'b10,
        OPA_ZERO = 2'b11
    } opa_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic        mem_wen;
        logic        wb_sel;
        logic        branch_op;
        logic        op_b_sel;
        opa_e        op_a_sel;
        logic [5:0]  alu_ctrl;
        logic [31:0] imm;
        logic        illegal;
    } ctrl_t;

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction
endpackage

// File: rtl/decode_stage_pipe_if.sv
// decode_stage_pipe_if: fetch-side and execute-side handshake/bus signals of the decode stage
interface decode_stage_pipe_if #(parameter int ADDRESS_BITS = 16);
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDRESS_BITS-1:0] PC;
    logic [31:0]             instruction;
    logic                    flush;
    logic                    out_ready;
    logic                    out_valid;
    logic [ADDRESS_BITS-1:0] out_PC;
    logic [4:0]              read_sel1;
    logic [4:0]              read_sel2;
    logic [4:0]              write_sel;
    logic                    wEn;
    logic                    mem_wEn;
    logic                    wb_sel;
    logic                    branch_op;
    logic                    op_B_sel;
    logic [1:0]              op_A_sel;
    logic [5:0]              ALU_Control;
    logic [31:0]             imm32;
    logic                    illegal;
    logic                    jump_valid;
    logic [ADDRESS_BITS-1:0] target_PC;

    modport master (
        output in_valid, PC, instruction, flush, out_ready,
        input  in_ready, out_valid, out_PC, read_sel1, read_sel2, write_sel, wEn, mem_wEn,
               wb_sel, branch_op, op_B_sel, op_A_sel, ALU_Control, imm32, illegal,
               jump_valid, target_PC
    );

    modport slave (
        input  in_valid, PC, instruction, flush, out_ready,
        output in_ready, out_valid, out_PC, read_sel1, read_sel2, write_sel, wEn, mem_wEn,
               wb_sel, branch_op, op_B_sel, op_A_sel, ALU_Control, imm32, illegal,
               jump_valid, target_PC
    );
endinterface

// File: rtl/decode_core.sv
// decode_core: combinational RV32I field/control decode; unsupported encodings become a flagged NOP
module decode_core
    import riscv_decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        rs1_used_o,
    output logic        rs2_used_o
);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic [31:0] ins;
    logic [6:0]  opc;

    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];

    always_comb begin
        legal = 1'b0;
        case (instr_i[6:0])
            OP:              legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            OP_IMM:          legal = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            LOAD:            legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            STORE:           legal = f3 inside {3'b000, 3'b001, 3'b010};
            BRANCH:          legal = !(f3 inside {3'b010, 3'b011});
            JALR:            legal = f3 == 3'b000;
            JAL, LUI, AUIPC: legal = 1'b1;
            default:         legal = 1'b0;
        endcase
    end

    // Everything below decodes the substituted word, so an illegal input looks exactly like addi x0,x0,0
    assign ins = legal ? instr_i : NOP;
    assign opc = ins[6:0];

    always_comb begin
        ctrl_o           = '0;
        ctrl_o.rs1       = ins[19:15];
        ctrl_o.rs2       = ins[24:20];
        ctrl_o.rd        = ins[11:7];
        ctrl_o.wen       = opc inside {OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC} && ins[11:7] != 5'd0;
        ctrl_o.mem_wen   = opc == STORE;
        ctrl_o.wb_sel    = opc == LOAD;
        ctrl_o.branch_op = opc == BRANCH;
        ctrl_o.op_b_sel  = !(opc == OP || opc == BRANCH);
        ctrl_o.op_a_sel  = opc == LUI ? OPA_ZERO : opc == AUIPC ? OPA_PC
                         : (opc == JAL || opc == JALR) ? OPA_PC4 : OPA_RS1;
        ctrl_o.alu_ctrl  = opc == OP ? {2'b00, ins[30], ins[14:12]}
                         : opc == OP_IMM ? {2'b00, ins[14:12] == 3'b101 && ins[30], ins[14:12]}
                         : opc == BRANCH ? {3'b010, ins[14:12]} : ALU_ADD;
        ctrl_o.imm       = opc == STORE ? {{20{ins[31]}}, ins[31:25], ins[11:7]}
                         : opc == BRANCH ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}
                         : (opc == LUI || opc == AUIPC) ? {ins[31:12], 12'b0}
                         : opc == JAL ? imm_j(ins)
                         : opc == OP ? 32'd0 : {{20{ins[31]}}, ins[31:20]};
        ctrl_o.illegal   = !legal;
    end

    assign rs1_used_o = !(opc == LUI || opc == AUIPC || opc == JAL);
    assign rs2_used_o = opc == OP || opc == STORE || opc == BRANCH;
endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered ID/EX stage with load-use interlock, flush, early JAL redirect
module decode_stage_pipe
    import riscv_decode_pkg::*;
#(
    parameter int ADDRESS_BITS  = 16,
    parameter bit STALL_ON_LOAD = 1'b1,
    parameter bit EARLY_JAL     = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    decode_stage_pipe_if.slave bus
);
    ctrl_t                   dec;
    ctrl_t                   ctrl_q, ctrl_d;
    logic [ADDRESS_BITS-1:0] pc_q, pc_d;
    logic                    valid_q, valid_d;
    logic                    rs1_used, rs2_used;
    logic                    advance, hazard, accept;

    decode_core u_core (
        .instr_i    (bus.instruction),
        .ctrl_o     (dec),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used)
    );

    always_comb begin
        advance = !valid_q || bus.out_ready;
        hazard = STALL_ON_LOAD && valid_q && ctrl_q.wb_sel && !ctrl_q.mem_wen && ctrl_q.rd != 5'd0
               && bus.in_valid && ((rs1_used && dec.rs1 == ctrl_q.rd) || (rs2_used && dec.rs2 == ctrl_q.rd));
        bus.in_ready = reset && advance && !hazard && !bus.flush;
        accept = bus.in_valid && bus.in_ready;
        // A hazard bubble or an empty input both clear valid; only a stalled output holds it
        valid_d = !bus.flush && (accept || (!advance && valid_q));
        ctrl_d = accept ? dec : ctrl_q;
        pc_d = accept ? bus.PC : pc_q;
        bus.jump_valid = EARLY_JAL && accept && bus.instruction[6:0] == JAL;
        bus.target_PC = bus.PC + ADDRESS_BITS'(imm_j(bus.instruction));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_PC      = pc_q;
    assign bus.read_sel1   = ctrl_q.rs1;
    assign bus.read_sel2   = ctrl_q.rs2;
    assign bus.write_sel   = ctrl_q.rd;
    assign bus.wEn         = ctrl_q.wen;
    assign bus.mem_wEn     = ctrl_q.mem_wen;
    assign bus.wb_sel      = ctrl_q.wb_sel;
    assign bus.branch_op   = ctrl_q.branch_op;
    assign bus.op_B_sel    = ctrl_q.op_b_sel;
    assign bus.op_A_sel    = ctrl_q.op_a_sel;
    assign bus.ALU_Control = ctrl_q.alu_ctrl;
    assign bus.imm32       = ctrl_q.imm;
    assign bus.illegal     = ctrl_q.illegal;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: table-driven cycle vectors on the default build, plus a no-interlock/no-early-JAL build
module tb_decode_stage_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    decode_stage_pipe_if #(.ADDRESS_BITS(16)) a ();
    decode_stage_pipe_if #(.ADDRESS_BITS(16)) b ();

    decode_stage_pipe #(.ADDRESS_BITS(16)) dut_a (.clock(clk), .reset(rst_n), .bus(a.slave));
    decode_stage_pipe #(.ADDRESS_BITS(16), .STALL_ON_LOAD(1'b0), .EARLY_JAL(1'b0)) dut_b (
        .clock(clk), .reset(rst_n), .bus(b.slave));

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic [15:0] pc;
        logic        fl;
        logic        ordy;
        logic        rdy;
        logic        jv;
        logic [15:0] tgt;
        logic        ov;
        logic [15:0] opc;
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        wen;
        logic        wb;
        logic        mw;
        logic        ill;
        logic [5:0]  alu;
        logic [31:0] imm;
    } vec_t;

    vec_t v[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic b_step(input logic iv, input logic [31:0] ins, input logic [15:0] pc);
        @(negedge clk);
        b.in_valid = iv;
        b.instruction = ins;
        b.PC = pc;
    endtask

    initial begin
        // iv ins pc fl ordy | rdy jv tgt | ov opc rd r1 r2 wen wb mw ill alu imm
        v[0]  = '{1'b1, 32'h00C58833, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0100, 5'd16, 5'd11, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 32'd0};
        v[1]  = '{1'b1, 32'h0005A903, 16'h0104, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0104, 5'd18, 5'd11, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 32'd0};
        v[2]  = '{1'b1, 32'h00B90533, 16'h0108, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0,    5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 32'd0};
        v[3]  = '{1'b1, 32'h00B90533, 16'h0108, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0108, 5'd10, 5'd18, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 32'd0};
        v[4]  = '{1'b1, 32'h40E608B3, 16'h010C, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h010C, 5'd17, 5'd12, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 6'h08, 32'd0};
        v[5]  = '{1'b1, 32'h00C58833, 16'h0110, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h010C, 5'd17, 5'd12, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 6'h08, 32'd0};
        v[6]  = v[5];
        v[7]  = v[5];
        v[8]  = '{1'b1, 32'h00C58833, 16'h0110, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0110, 5'd16, 5'd11, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 32'd0};
        v[9]  = '{1'b1, 32'h0140006F, 16'h0114, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0128, 1'b1, 16'h0114, 5'd0, 5'd0, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 32'd20};
        v[10] = '{1'b1, 32'h00C58833, 16'h0128, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0,    5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 32'd0};
        v[11] = '{1'b1, 32'h00C58833, 16'h0128, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0128, 5'd16, 5'd11, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 32'd0};
        v[12] = '{1'b1, 32'hFFFFFFFF, 16'h012C, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h012C, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 32'd0};
        v[13] = '{1'b1, 32'h40E608B3, 16'h0130, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0130, 5'd17, 5'd12, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 6'h08, 32'd0};
        v[14] = '{1'b0, 32'h00000000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0,    5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 32'd0};
        v[15] = '{1'b1, 32'h014000EF, 16'hFFF0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'hFFF0, 5'd1, 5'd0, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 32'd20};

        a.in_valid = 1'b1; a.instruction = 32'h0140006F; a.PC = 16'h0114; a.flush = 1'b0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.instruction = 32'h0;        b.PC = 16'h0;    b.flush = 1'b0; b.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst.jump_valid", 32'(a.jump_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(a.out_valid), 32'd0);
        chk("rst.write_sel", 32'(a.write_sel), 32'd0);
        chk("rst.wEn", 32'(a.wEn), 32'd0);
        chk("rst.imm32", a.imm32, 32'd0);
        chk("rst.out_PC", 32'(a.out_PC), 32'd0);
        chk("rst.b_out_valid", 32'(b.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            a.in_valid = v[i].iv;
            a.instruction = v[i].ins;
            a.PC = v[i].pc;
            a.flush = v[i].fl;
            a.out_ready = v[i].ordy;
            #1;
            chk($sformatf("r%0d.in_ready", i), 32'(a.in_ready), 32'(v[i].rdy));
            chk($sformatf("r%0d.jump_valid", i), 32'(a.jump_valid), 32'(v[i].jv));
            if (v[i].jv)
                chk($sformatf("r%0d.target_PC", i), 32'(a.target_PC), 32'(v[i].tgt));
            @(posedge clk);
            #1;
            chk($sformatf("r%0d.out_valid", i), 32'(a.out_valid), 32'(v[i].ov));
            if (v[i].ov) begin
                chk($sformatf("r%0d.out_PC", i), 32'(a.out_PC), 32'(v[i].opc));
                chk($sformatf("r%0d.write_sel", i), 32'(a.write_sel), 32'(v[i].rd));
                chk($sformatf("r%0d.read_sel1", i), 32'(a.read_sel1), 32'(v[i].r1));
                chk($sformatf("r%0d.read_sel2", i), 32'(a.read_sel2), 32'(v[i].r2));
                chk($sformatf("r%0d.wEn", i), 32'(a.wEn), 32'(v[i].wen));
                chk($sformatf("r%0d.wb_sel", i), 32'(a.wb_sel), 32'(v[i].wb));
                chk($sformatf("r%0d.mem_wEn", i), 32'(a.mem_wEn), 32'(v[i].mw));
                chk($sformatf("r%0d.illegal", i), 32'(a.illegal), 32'(v[i].ill));
                chk($sformatf("r%0d.ALU_Control", i), 32'(a.ALU_Control), 32'(v[i].alu));
                chk($sformatf("r%0d.imm32", i), a.imm32, v[i].imm);
            end
            @(negedge clk);
        end
        a.in_valid = 1'b0;

        // no interlock: load then dependent add flow back to back; JAL never redirects
        b.out_ready = 1'b1;
        b_step(1'b1, 32'h0005A903, 16'h0200);
        #1;
        chk("b.lw.in_ready", 32'(b.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("b.lw.write_sel", 32'(b.write_sel), 32'd18);
        b_step(1'b1, 32'h00B90533, 16'h0204);
        #1;
        chk("b.add.in_ready", 32'(b.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("b.add.out_valid", 32'(b.out_valid), 32'd1);
        chk("b.add.write_sel", 32'(b.write_sel), 32'd10);
        chk("b.add.read_sel1", 32'(b.read_sel1), 32'd18);
        b_step(1'b1, 32'h0140006F, 16'h0114);
        #1;
        chk("b.jal.in_ready", 32'(b.in_ready), 32'd1);
        chk("b.jal.jump_valid", 32'(b.jump_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("b.jal.out_valid", 32'(b.out_valid), 32'd1);
        chk("b.jal.wEn", 32'(b.wEn), 32'd0);
        chk("b.jal.imm32", b.imm32, 32'd20);
        b_step(1'b0, 32'h0, 16'h0);
        @(posedge clk);
        #1;
        chk("b.idle.out_valid", 32'(b.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
